// File: rtl/klp32_dmem_responder_pkg.sv
// Shared KLP32 load/store definitions: funct3 encodings, responder FSM states
// and store lane helpers.
package klp32_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3)
      F3_SB:   be = 4'b0001 << lo;
      F3_SH:   be = lo[1] ? 4'b1100 : 4'b0011;
      F3_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the low bits so every enabled lane sees its byte in place.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] lanes;
    case (f3)
      F3_SB:   lanes = {4{w[7:0]}};
      F3_SH:   lanes = {2{w[15:0]}};
      default: lanes = w;
    endcase
    return lanes;
  endfunction

  function automatic logic req_bad_op(input logic we, input logic [2:0] f3, input logic [1:0] lo);
    logic misaligned;
    logic illegal;
    misaligned = ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    illegal    = we ? (f3 > F3_SW) : ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
    return misaligned || illegal;
  endfunction

endpackage

// File: rtl/klp32_dmem_responder_if.sv
// Load/store request and response channels between the KLP32 core (master)
// and the data-memory responder (slave).
interface klp32_dmem_responder_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [2:0]  i_req_funct3;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_funct3, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_funct3, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/klp32_dmem_responder_load_extend.sv
// Extracts the addressed byte/halfword from a memory word and sign- or
// zero-extends it according to the load funct3.
module klp32_load_extend
  import klp32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] rdata
);

  logic [15:0]        shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    shifted = 16'(word >> {addr_lo, 3'b000});
    byte_s  = signed'(shifted[7:0]);
    half_s  = signed'(shifted[15:0]);
    rdata   = '0;
    case (funct3)
      F3_LB:   rdata = 32'(byte_s);
      F3_LH:   rdata = 32'(half_s);
      F3_LW:   rdata = word;
      F3_LBU:  rdata = {24'd0, shifted[7:0]};
      F3_LHU:  rdata = {16'd0, shifted[15:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/klp32_dmem_responder.sv
// KLP32 data-memory responder: one outstanding load/store at a time against an
// internal byte-enabled word array, with WAIT_CYCLES wait states per access.
module klp32_dmem_responder
  import klp32_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input logic                   clk,
  input logic                   reset,
  klp32_dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic          we_q, we_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    f3_q, f3_d;

  logic          req_err;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [31:0]   ld_data;
  logic          mem_wr;
  logic [3:0]    wr_be;
  logic [31:0]   wr_lanes;

  assign req_err  = req_bad_op(bus.i_req_we, bus.i_req_funct3, bus.i_req_addr[1:0]) ||
                    ((bus.i_req_addr >> (AW + 2)) != 32'd0);
  assign word_idx = addr_q[AW+1:2];
  assign rd_word  = mem[word_idx];
  assign mem_wr   = (state_q == WAIT) && (cnt_q == 4'd0) && we_q;
  assign wr_be    = store_be(f3_q, addr_q[1:0]);
  assign wr_lanes = store_lanes(f3_q, wdata_q);

  klp32_load_extend u_load_extend (
    .funct3  (f3_q),
    .addr_lo (addr_q[1:0]),
    .word    (rd_word),
    .rdata   (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    case (state_q)
      IDLE: begin
        if (bus.i_req_valid && req_ready_q) begin
          we_d        = bus.i_req_we;
          addr_d      = bus.i_req_addr[AW+1:0];
          wdata_d     = bus.i_req_wdata;
          f3_d        = bus.i_req_funct3;
          req_ready_d = 1'b0;
          if (req_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        // Access edge: memory is read and written here; read sees pre-write data.
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'd0 : ld_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.i_rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Latched request fields are plain data and need no reset.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    f3_q    <= f3_d;
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  assign bus.o_req_ready = req_ready_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_rdata = rsp_rdata_q;
  assign bus.o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_klp32_dmem_responder.sv
// Directed bench for klp32_dmem_responder: three instances (WAIT_CYCLES 1/3/0)
// receive identical requests; the WAIT_CYCLES=1 instance carries the data checks.
module tb_klp32_dmem_responder;
  import klp32_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  klp32_dmem_responder_if b1();
  klp32_dmem_responder_if b3();
  klp32_dmem_responder_if b0();

  klp32_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  klp32_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u3 (.clk(clk), .reset(reset), .bus(b3));
  klp32_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u0 (.clk(clk), .reset(reset), .bus(b0));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic v, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f);
    b1.i_req_valid = v; b1.i_req_we = we; b1.i_req_addr = a; b1.i_req_wdata = wd; b1.i_req_funct3 = f;
    b3.i_req_valid = v; b3.i_req_we = we; b3.i_req_addr = a; b3.i_req_wdata = wd; b3.i_req_funct3 = f;
    b0.i_req_valid = v; b0.i_req_we = we; b0.i_req_addr = a; b0.i_req_wdata = wd; b0.i_req_funct3 = f;
  endtask

  task automatic set_rsp_ready(input logic r);
    b1.i_rsp_ready = r;
    b3.i_rsp_ready = r;
    b0.i_rsp_ready = r;
  endtask

  // Counts edges after the call point until b1 shows a response (0 = timeout).
  task automatic wait_rsp1(output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (b1.o_rsp_valid) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] f, input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    int l1, l3, l0;
    rd = 'x; er = 1'bx; l1 = 0; l3 = 0; l0 = 0;
    @(negedge clk);
    drive_req(1'b1, we, a, wd, f);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    for (int n = 1; n <= 40 && (l1 == 0 || l3 == 0 || l0 == 0); n++) begin
      @(posedge clk); #1;
      if (l1 == 0 && b1.o_rsp_valid) begin
        l1 = n; rd = b1.o_rsp_rdata; er = b1.o_rsp_err;
      end
      if (l3 == 0 && b3.o_rsp_valid) l3 = n;
      if (l0 == 0 && b0.o_rsp_valid) l0 = n;
    end
    set_rsp_ready(1'b1);
    @(posedge clk); #1;
    set_rsp_ready(1'b0);
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".err"}, {31'd0, er}, {31'd0, exp_er});
    chk({tag, ".lat_w1"}, l1, exp_er ? 32'd1 : 32'd2);
    chk({tag, ".lat_w3"}, l3, exp_er ? 32'd1 : 32'd4);
    chk({tag, ".lat_w0"}, l0, 32'd1);
  endtask

  int n;

  initial begin
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    set_rsp_ready(1'b0);
    repeat (2) @(negedge clk);
    chk("rst.req_ready", {31'd0, b1.o_req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'd0, b1.o_rsp_valid}, 32'd0);
    chk("rst.rdata", b1.o_rsp_rdata, 32'd0);
    chk("rst.err", {31'd0, b1.o_rsp_err}, 32'd0);
    reset = 1'b0;

    run("sw_f0", 1'b1, 32'h0000_00F0, 32'h0000_0004, F3_SW, 32'd0, 1'b0);
    run("lw_f0", 1'b0, 32'h0000_00F0, 32'd0, F3_LW, 32'h0000_0004, 1'b0);
    run("sw_f0b", 1'b1, 32'h0000_00F0, 32'h1122_3344, F3_SW, 32'd0, 1'b0);
    run("sb_f1", 1'b1, 32'h0000_00F1, 32'hABCD_EF80, F3_SB, 32'd0, 1'b0);
    run("lb_f1", 1'b0, 32'h0000_00F1, 32'd0, F3_LB, 32'hFFFF_FF80, 1'b0);
    run("lbu_f1", 1'b0, 32'h0000_00F1, 32'd0, F3_LBU, 32'h0000_0080, 1'b0);
    run("lw_f0b", 1'b0, 32'h0000_00F0, 32'd0, F3_LW, 32'h1122_8044, 1'b0);
    run("sh_f2", 1'b1, 32'h0000_00F2, 32'h1234_8001, F3_SH, 32'd0, 1'b0);
    run("lh_f2", 1'b0, 32'h0000_00F2, 32'd0, F3_LH, 32'hFFFF_8001, 1'b0);
    run("lhu_f2", 1'b0, 32'h0000_00F2, 32'd0, F3_LHU, 32'h0000_8001, 1'b0);
    run("lb_f0", 1'b0, 32'h0000_00F0, 32'd0, F3_LB, 32'h0000_0044, 1'b0);
    run("lw_f0c", 1'b0, 32'h0000_00F0, 32'd0, F3_LW, 32'h8001_8044, 1'b0);

    run("sw_100", 1'b1, 32'h0000_0100, 32'hCAFE_F00D, F3_SW, 32'd0, 1'b0);
    run("sw_3fc", 1'b1, 32'h0000_03FC, 32'h5A5A_A5A5, F3_SW, 32'd0, 1'b0);
    run("lw_3fc", 1'b0, 32'h0000_03FC, 32'd0, F3_LW, 32'h5A5A_A5A5, 1'b0);
    run("lw_102_mis", 1'b0, 32'h0000_0102, 32'd0, F3_LW, 32'd0, 1'b1);
    run("sh_103_mis", 1'b1, 32'h0000_0103, 32'h0000_FFFF, F3_SH, 32'd0, 1'b1);
    run("lw_400_oor", 1'b0, 32'h0000_0400, 32'd0, F3_LW, 32'd0, 1'b1);
    run("sw_400_oor", 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, F3_SW, 32'd0, 1'b1);
    run("st_f3_3", 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 3'd3, 32'd0, 1'b1);
    run("ld_f3_6", 1'b0, 32'h0000_0100, 32'd0, 3'd6, 32'd0, 1'b1);
    run("lw_100_kept", 1'b0, 32'h0000_0100, 32'd0, F3_LW, 32'hCAFE_F00D, 1'b0);

    // Backpressure with a second request held on the bus.
    @(negedge clk);
    b1.i_req_valid = 1'b1; b1.i_req_we = 1'b0; b1.i_req_addr = 32'h0000_00F0;
    b1.i_req_wdata = 32'd0; b1.i_req_funct3 = F3_LW;
    @(posedge clk); #1;
    chk("bp.busy_ready", {31'd0, b1.o_req_ready}, 32'd0);
    b1.i_req_addr = 32'h0000_0100;
    wait_rsp1(n);
    chk("bp.lat", n, 32'd2);
    chk("bp.rdata", b1.o_rsp_rdata, 32'h8001_8044);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp.hold_valid", {31'd0, b1.o_rsp_valid}, 32'd1);
      chk("bp.hold_rdata", b1.o_rsp_rdata, 32'h8001_8044);
      chk("bp.hold_err", {31'd0, b1.o_rsp_err}, 32'd0);
      chk("bp.hold_ready", {31'd0, b1.o_req_ready}, 32'd0);
    end
    b1.i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b1.i_rsp_ready = 1'b0;
    chk("bp.hs_ready", {31'd0, b1.o_req_ready}, 32'd1);
    chk("bp.hs_valid", {31'd0, b1.o_rsp_valid}, 32'd0);
    chk("bp.hs_rdata", b1.o_rsp_rdata, 32'd0);
    @(posedge clk); #1;
    chk("bp.next_accept", {31'd0, b1.o_req_ready}, 32'd0);
    b1.i_req_valid = 1'b0;
    wait_rsp1(n);
    chk("bp.next_lat", n, 32'd2);
    chk("bp.next_rdata", b1.o_rsp_rdata, 32'hCAFE_F00D);
    b1.i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b1.i_rsp_ready = 1'b0;

    // Reset in WAIT, one edge before the store would commit.
    run("sw_10_zero", 1'b1, 32'h0000_0010, 32'd0, F3_SW, 32'd0, 1'b0);
    @(negedge clk);
    b1.i_req_valid = 1'b1; b1.i_req_we = 1'b1; b1.i_req_addr = 32'h0000_0010;
    b1.i_req_wdata = 32'hDEAD_BEEF; b1.i_req_funct3 = F3_SW;
    @(posedge clk); #1;
    b1.i_req_valid = 1'b0;
    chk("rstw.busy", {31'd0, b1.o_req_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rstw.req_ready", {31'd0, b1.o_req_ready}, 32'd1);
    chk("rstw.rsp_valid", {31'd0, b1.o_rsp_valid}, 32'd0);
    chk("rstw.rdata", b1.o_rsp_rdata, 32'd0);
    chk("rstw.err", {31'd0, b1.o_rsp_err}, 32'd0);
    #1;
    reset = 1'b0;
    run("lw_10_after_rst", 1'b0, 32'h0000_0010, 32'd0, F3_LW, 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/klp32_dmem_responder.md
# klp32_dmem_responder

Data-memory responder for the KLP32 core: the target end of the core's load/store interface. It accepts one request at a time over a valid/ready channel and performs RV32I byte, halfword and word accesses on an internal word array. It returns the load data (sign- or zero-extended) or an error over a second valid/ready channel. It sits between the core's load/store path and a simulation or FPGA data RAM, with a configurable number of wait states.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, ≥4.
- WAIT_CYCLES, 1: extra cycles between request accept and memory access; 0..15.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  responder can accept a request.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data, taken from the low bits per access size.
- i_req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU or SB/SH/SW).
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  consumer accepts the response.
- o_rsp_rdata  out  32  load result; 0 for stores and errors.
- o_rsp_err  out  1  request rejected.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - o_req_ready = 1. No other state drives it high, so at most one request is outstanding.
  - When i_req_valid & o_req_ready, the block latches we, addr, wdata and funct3.
  - If the request is an error, it goes to RESP with err=1.
  - Otherwise it loads the wait counter with WAIT_CYCLES and goes to WAIT.
- A request is an error when any of these holds:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - addr ≥ 4*DEPTH_WORDS.
  - Illegal funct3: loads 3/6/7, stores ≥3.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where counter==0, the access is performed and the FSM moves to RESP.
  - Store: only the addressed byte lanes are written. SB uses lane addr[1:0]; SH uses lanes {addr[1],0} and {addr[1],1}; SW uses all lanes.
  - Load: the word is read, the addressed byte/halfword is extracted and extended (LB/LH sign, LBU/LHU zero), and the result is registered into o_rsp_rdata.
- RESP:
  - o_rsp_valid = 1.
  - o_rsp_rdata and o_rsp_err are held stable until i_rsp_ready.
  - On the edge where o_rsp_valid & i_rsp_ready, the FSM returns to IDLE and clears o_rsp_rdata and o_rsp_err.
- Error requests never modify memory.
- Memory contents are not cleared by reset.

## Timing
- Reset values: o_req_ready=1 (IDLE), o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, counter=0.
- Latency, accept edge E to first o_rsp_valid cycle:
  - Legal request: WAIT_CYCLES+1 edges. The store commits on edge E+WAIT_CYCLES+1.
  - Error request: 1 edge.
- Throughput without backpressure: one request per WAIT_CYCLES+3 cycles. A new request cannot be accepted on the same edge a response completes.
- i_req_* are sampled only on the accept edge. Changes to them afterwards have no effect.
- Reset asserted mid-transaction:
  - FSM goes to IDLE immediately and outputs take their reset values.
  - A store whose commit edge has not yet occurred is not written.
  - The pending response is dropped.
- Loads return the memory value from before any store that commits on the same edge. Such a case cannot arise because only one request is outstanding; nonetheless, the read happens before the write.

## Structure
- Package klp32_pkg holds:
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
  - State enum dmem_state_t {IDLE, WAIT, RESP}.
- Sub-module klp32_load_extend: combinational; inputs funct3, addr[1:0], word; output extended 32-bit load data. Reused later by the core's writeback path.
- Memory is a plain reg array with per-byte write enables, inferable as block RAM.

## Test plan
- SW 0x00000004 to 0x000000F0, then LW 0x000000F0 -> rdata 0x00000004, err 0; store response rdata 0.
- SB 0x80 to 0x000000F1 over word 0x11223344, then LB 0xF1 -> 0xFFFFFF80; LBU 0xF1 -> 0x00000080; LW 0xF0 -> 0x11228044.
- LW 0x00000102, SH 0x00000103, LW 0x00000400 (DEPTH 256) -> each err=1, rdata 0, latency 1; target words unchanged.
- Backpressure: hold i_rsp_ready=0 for 5 cycles after o_rsp_valid -> o_rsp_valid, o_rsp_rdata and o_rsp_err stable; o_req_ready=0 throughout; i_req_valid held high is not accepted until one edge after the response handshake.
- WAIT_CYCLES=3: request accepted at edge E -> o_rsp_valid rises after edge E+4. Same check with WAIT_CYCLES=0 -> rises after E+1.
- Reset pulse during WAIT of SW 0xDEADBEEF to 0x10 (old value 0x0) -> outputs at reset values; LW 0x10 afterwards -> 0x00000000.
